regalu_pipe: RTL and testbench

- Pipelined, parametrised successor to the single-cycle register-file/ALU/data-memory datapath.
- Splits execution into three stages: E (issue, operand read, ALU), M (data-memory access), W (writeback).
- Adds a valid/ready issue handshake, full operand forwarding and load-use stall detection.
- Sits between the decode/control unit and an external synchronous data memory with 1-cycle read latency.

---
 rtl/regalu_pkg.sv | 27 ++
 rtl/regalu_fwd_unit.sv | 49 ++++
 rtl/regalu_pipe.sv | 155 +++++++++++++++
 tb/tb_regalu_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regalu_pkg.sv
// Shared types for the regalu_pipe E/M/W datapath.
// Holds ALU opcodes, forwarding selects and the control-bit bundle.
package regalu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_e;

    // Control bits carried with an instruction down the pipe.
    typedef struct packed {
        logic reg_write;
        logic result_src;
        logic mem_write;
        logic jal_sel;
    } ctrl_t;

endpackage

// File: rtl/regalu_fwd_unit.sv
// Operand forwarding select and load-use stall detection.
// In: rs1_i/rs2_i, M and W stage valid/rd/control. Out: fwd1_o, fwd2_o, stall_o.
module regalu_fwd_unit
    import regalu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] rs1_i,
    input  logic [ADDRESS_WIDTH-1:0] rs2_i,
    input  logic                     m_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] m_rd_i,
    input  logic                     m_reg_write_i,
    input  logic                     m_load_i,
    input  logic                     w_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] w_rd_i,
    input  logic                     w_reg_write_i,
    output fwd_sel_e                 fwd1_o,
    output fwd_sel_e                 fwd2_o,
    output logic                     stall_o
);

    logic m_wr;
    logic w_wr;

    // A nonzero rd is required, so a match also implies a nonzero source.
    assign m_wr = m_valid_i & m_reg_write_i & (m_rd_i != '0);
    assign w_wr = w_valid_i & w_reg_write_i & (w_rd_i != '0);

    // A load in M has no data yet; it is covered by the stall instead.
    always_comb begin
        fwd1_o = FWD_RF;
        fwd2_o = FWD_RF;
        if (m_wr && !m_load_i && rs1_i == m_rd_i) begin
            fwd1_o = FWD_M;
        end else if (w_wr && rs1_i == w_rd_i) begin
            fwd1_o = FWD_W;
        end
        if (m_wr && !m_load_i && rs2_i == m_rd_i) begin
            fwd2_o = FWD_M;
        end else if (w_wr && rs2_i == w_rd_i) begin
            fwd2_o = FWD_W;
        end
    end

    // rs2 is checked even for immediate ops; costs a rare extra bubble.
    assign stall_o = m_wr & m_load_i &
                     ((rs1_i == m_rd_i) | (rs2_i == m_rd_i));

endmodule

// File: rtl/regalu_pipe.sv
// Three-stage (E/M/W) register-file/ALU/data-memory datapath.
// Ports: issue handshake in, forwarded rd1/eq out, M-stage memory bus, wb_valid, a0.
module regalu_pipe
    import regalu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int PC_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic                     RegWrite,
    input  logic                     ALUSrc,
    input  logic                     ResultSrc,
    input  logic                     MemWrite,
    input  logic                     jalmuxSel,
    input  logic [2:0]               ALUControl,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic [PC_WIDTH-1:0]      PC,
    output logic                     eq,
    output logic [DATA_WIDTH-1:0]    rd1,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     wb_valid,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int NREG = 2 ** ADDRESS_WIDTH;

    typedef struct packed {
        logic                     valid;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    result;
        logic [DATA_WIDTH-1:0]    wdata;
        logic [DATA_WIDTH-1:0]    pc4;
        ctrl_t                    ctrl;
    } stage_t;

    stage_t                m_q, m_d, w_q;
    logic [DATA_WIDTH-1:0] rf_q [NREG];
    fwd_sel_e              fwd1, fwd2;
    logic                  stall, issue, rf_we;
    logic [DATA_WIDTH-1:0] m_res, w_res, fa, fb, op_b, alu_res;
    logic [PC_WIDTH-1:0]   pc_next;
    logic                  unused_w;

    regalu_fwd_unit #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd (
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .m_valid_i     (m_q.valid),
        .m_rd_i        (m_q.rd),
        .m_reg_write_i (m_q.ctrl.reg_write),
        .m_load_i      (m_q.ctrl.result_src),
        .w_valid_i     (w_q.valid),
        .w_rd_i        (w_q.rd),
        .w_reg_write_i (w_q.ctrl.reg_write),
        .fwd1_o        (fwd1),
        .fwd2_o        (fwd2),
        .stall_o       (stall)
    );

    assign in_ready = rst_n & ~stall;
    assign issue    = in_valid & in_ready;

    assign m_res = m_q.ctrl.jal_sel ? m_q.pc4 : m_q.result;
    assign w_res = w_q.ctrl.jal_sel    ? w_q.pc4   :
                   w_q.ctrl.result_src ? mem_rdata : w_q.result;

    // The W value is forwarded, so a same-cycle write never reads stale.
    always_comb begin
        unique case (fwd1)
            FWD_M:   fa = m_res;
            FWD_W:   fa = w_res;
            default: fa = rf_q[rs1];
        endcase
        unique case (fwd2)
            FWD_M:   fb = m_res;
            FWD_W:   fb = w_res;
            default: fb = rf_q[rs2];
        endcase
    end

    assign op_b = ALUSrc ? ImmOp : fb;

    always_comb begin
        alu_res = '0;
        unique case (alu_op_e'(ALUControl))
            ALU_ADD: alu_res = fa + op_b;
            ALU_SUB: alu_res = fa - op_b;
            ALU_AND: alu_res = fa & op_b;
            ALU_OR:  alu_res = fa | op_b;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}},
                                $signed(fa) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    assign eq  = (alu_res == '0);
    assign rd1 = fa;

    assign pc_next = PC + PC_WIDTH'(4);

    always_comb begin
        m_d                 = '0;
        m_d.valid           = issue;
        m_d.rd              = rd;
        m_d.result          = alu_res;
        m_d.wdata           = fb;
        m_d.pc4             = DATA_WIDTH'(pc_next);
        m_d.ctrl.reg_write  = RegWrite;
        m_d.ctrl.result_src = ResultSrc;
        m_d.ctrl.mem_write  = MemWrite;
        m_d.ctrl.jal_sel    = jalmuxSel;
    end

    // Payloads are cleared too so the memory bus idles at zero in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= m_q;
        end
    end

    assign rf_we = w_q.valid & w_q.ctrl.reg_write & (w_q.rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[w_q.rd] <= w_res;
        end
    end

    assign mem_addr  = m_q.result;
    assign mem_wdata = m_q.wdata;
    assign mem_we    = m_q.valid & m_q.ctrl.mem_write;
    assign wb_valid  = w_q.valid;
    assign a0        = rf_q[10];

    // Store data and the write strobe are finished with once past M.
    assign unused_w = ^{w_q.wdata, w_q.ctrl.mem_write};

endmodule

// File: tb/tb_regalu_pipe.sv
// Scoreboard bench for regalu_pipe: directed instruction vectors,
// retire-latency and store queues checked by a separate monitor.
module tb_regalu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite, ALUSrc, ResultSrc, MemWrite, jalmuxSel;
    logic [2:0]  ALUControl;
    logic [31:0] ImmOp, PC;
    logic        eq;
    logic [31:0] rd1, mem_addr, mem_wdata, mem_rdata, a0;
    logic        mem_we, wb_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int rq[$];
    logic [63:0] sq[$];

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] SLT = 3'b101;

    regalu_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .ResultSrc(ResultSrc), .MemWrite(MemWrite), .jalmuxSel(jalmuxSel),
        .ALUControl(ALUControl), .ImmOp(ImmOp), .PC(PC), .eq(eq), .rd1(rd1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .a0(a0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency data memory holding a single known word.
    always @(posedge clk)
        mem_rdata <= (mem_addr == 32'h40) ? 32'hDEADBEEF : 32'h0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endfunction

    // Monitor: retire latency and store bus contents.
    always @(negedge clk) begin
        logic [63:0] e;
        if (wb_valid === 1'b1) begin
            if (rq.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else chk("wb_latency", 32'(cyc), 32'(rq.pop_front() + 2));
        end
        if (mem_we === 1'b1) begin
            if (sq.size() == 0) begin
                chk("store_unexpected", 32'd1, 32'd0);
            end else begin
                e = sq.pop_front();
                chk("store_addr", mem_addr, e[63:32]);
                chk("store_wdata", mem_wdata, e[31:0]);
            end
        end
    end

    // ctl = {RegWrite, ALUSrc, ResultSrc, MemWrite, jalmuxSel}
    task automatic drive(input logic [4:0] r1, r2, d, input logic [2:0] op,
                         input logic [31:0] imm, input logic [4:0] ctl,
                         input logic [31:0] pc = 32'h0);
        in_valid = 1'b1;
        rs1 = r1; rs2 = r2; rd = d;
        ALUControl = op; ImmOp = imm; PC = pc;
        {RegWrite, ALUSrc, ResultSrc, MemWrite, jalmuxSel} = ctl;
    endtask

    task automatic fire(output int stalls);
        stalls = 0;
        #3;
        while (in_ready !== 1'b1) begin
            if (stalls == 8) begin
                chk("issue_timeout", 32'd0, 32'd1);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "issue timeout");
            end
            stalls++;
            @(posedge clk);
            #4;
        end
        issue_cyc = cyc;
    endtask

    task automatic accept(input logic st = 1'b0, input logic [31:0] ea = 0,
                          input logic [31:0] ew = 0);
        @(posedge clk);
        #1;
        rq.push_back(issue_cyc);
        if (st) sq.push_back({ea, ew});
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [4:0] r, input logic [31:0] exp, input string nm);
        int s;
        drive(r, 5'd0, 5'd0, ADD, 32'h0, 5'b00000);
        fire(s);
        chk(nm, rd1, exp);
        accept();
    endtask

    initial begin
        int s;
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, ADD, 32'h0, 5'b00000);
        repeat (2) @(posedge clk);
        #4;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_a0", a0, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle(1);

        // addi x1,x0,5 ; add x2,x1,x1
        drive(5'd0, 5'd0, 5'd1, ADD, 32'd5, 5'b11000);
        fire(s);
        chk("addi_stall", 32'(s), 32'd0);
        chk("addi_rd1", rd1, 32'd0);
        chk("addi_eq", 32'(eq), 32'd0);
        accept();
        drive(5'd1, 5'd1, 5'd2, ADD, 32'd0, 5'b10000);
        fire(s);
        chk("add_nostall", 32'(s), 32'd0);
        chk("add_fwdM_rd1", rd1, 32'd5);
        accept();
        probe(5'd2, 32'd10, "x2_fwdM");
        idle(3);
        probe(5'd1, 32'd5, "x1_rf");
        probe(5'd2, 32'd10, "x2_rf");

        // lw x3,0x40(x0) ; add x4,x3,x0
        drive(5'd0, 5'd0, 5'd3, ADD, 32'h40, 5'b11100);
        fire(s);
        accept();
        drive(5'd3, 5'd0, 5'd4, ADD, 32'h0, 5'b10000);
        fire(s);
        chk("loaduse_stall", 32'(s), 32'd1);
        chk("load_fwdW", rd1, 32'hDEADBEEF);
        accept();
        idle(3);
        probe(5'd4, 32'hDEADBEEF, "x4_rf");

        // addi x6,x0,0x77 ; sw x6,8(x1)
        drive(5'd0, 5'd0, 5'd6, ADD, 32'h77, 5'b11000);
        fire(s);
        accept();
        drive(5'd1, 5'd6, 5'd0, ADD, 32'd8, 5'b01010);
        fire(s);
        chk("sw_rd1", rd1, 32'd5);
        accept(1'b1, 32'd13, 32'h77);

        // W-stage forward on same-cycle writeback
        drive(5'd0, 5'd0, 5'd11, ADD, 32'h33, 5'b11000);
        fire(s);
        accept();
        idle(1);
        probe(5'd11, 32'h33, "x11_fwdW");

        // sub x5,x6,x6 ; slt and undefined op
        drive(5'd6, 5'd6, 5'd5, SUB, 32'h0, 5'b10000);
        fire(s);
        chk("sub_eq", 32'(eq), 32'd1);
        accept();
        drive(5'd0, 5'd0, 5'd7, ADD, 32'hFFFF_FFFF, 5'b11000);
        fire(s);
        accept();
        drive(5'd7, 5'd0, 5'd8, SLT, 32'd1, 5'b11000);
        fire(s);
        chk("slt_rd1", rd1, 32'hFFFF_FFFF);
        chk("slt_eq", 32'(eq), 32'd0);
        accept();
        drive(5'd7, 5'd7, 5'd9, 3'b111, 32'h0, 5'b10000);
        fire(s);
        chk("op111_eq", 32'(eq), 32'd1);
        accept();
        idle(3);
        probe(5'd8, 32'd1, "x8_slt");

        // jal-style link into x10
        drive(5'd0, 5'd0, 5'd10, ADD, 32'h0, 5'b10001, 32'h100);
        fire(s);
        accept();
        @(posedge clk);
        #3;
        chk("jal_wb_valid", 32'(wb_valid), 32'd1);
        chk("a0_before", a0, 32'd0);
        @(posedge clk);
        #3;
        chk("a0_after", a0, 32'h104);
        @(posedge clk);
        #1;

        // writes to x0 are dropped
        drive(5'd0, 5'd0, 5'd0, ADD, 32'd99, 5'b11000);
        fire(s);
        accept();
        probe(5'd0, 32'd0, "x0_fwd");
        idle(3);
        probe(5'd0, 32'd0, "x0_rf");

        // reset with a store in M
        drive(5'd0, 5'd6, 5'd0, ADD, 32'h20, 5'b01010);
        fire(s);
        accept(1'b1, 32'h20, 32'h77);
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, ADD, 32'h0, 5'b00000);
        @(posedge clk);
        #1;
        rq.delete();
        #2;
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_a0", a0, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3;
        chk("mid_rst_in_ready2", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        probe(5'd10, 32'd0, "x10_cleared");
        probe(5'd1, 32'd0, "x1_cleared");

        idle(4);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        chk("sq_empty", 32'(sq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
